// File: rtl/stream_mux_pkg.sv
// Shared constants and width helper for the stream multiplexer slice.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Select width never drops below one bit, even for degenerate channel counts.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after 'last', wrapping at N.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = sel_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] last,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_vld
);

    always_comb begin
        int idx;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        // Walk k = 1..N so 'last' itself is visited last, only when it is the sole requester.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = SW'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N-to-1 valid/ready stream multiplexer with fixed or round-robin selection
// feeding a single registered output slot.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter  int W  = 8,
    parameter  int N  = 4,
    localparam int SW = sel_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [SW-1:0]  sel,
    input  logic           mode,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [SW-1:0] last;
    logic [SW-1:0] rr_idx;
    logic          rr_vld;
    logic          fixed_vld;
    logic [SW-1:0] gnt_idx;
    logic          gnt_vld;
    logic [W-1:0]  gnt_data;
    logic          can_load;
    logic          accept;

    rr_arbiter #(.N(N)) u_rr_arbiter (
        .req     (in_valid),
        .last    (last),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    // An out-of-range sel matches no channel, so it simply yields no grant.
    always_comb begin
        fixed_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SW'(i)) fixed_vld = in_valid[i];
        end
    end

    always_comb begin
        if (mode == MODE_RR) begin
            gnt_idx = rr_idx;
            gnt_vld = rr_vld;
        end else begin
            gnt_idx = sel;
            gnt_vld = fixed_vld;
        end
    end

    assign can_load = !out_valid || out_ready;
    assign accept   = gnt_vld && can_load && !rst;

    always_comb begin
        gnt_data = '0;
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == SW'(i)) begin
                gnt_data    = in_data[i*W +: W];
                in_ready[i] = accept;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            last      <= SW'(N - 1);
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            last      <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: a per-cycle vector table on a 4-channel
// instance plus hand sequences for async reset and a 3-channel instance.
module tb_stream_mux;
    import stream_mux_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] in_data4 = 32'h43A52110;
    logic [3:0]  in_valid4 = '0;
    logic [3:0]  in_ready4;
    logic [1:0]  sel4 = '0;
    logic        mode4 = MODE_FIXED;
    logic [7:0]  out_data4;
    logic        out_valid4;
    logic        out_ready4 = 1'b0;

    logic [23:0] in_data3 = 24'h030201;
    logic [2:0]  in_valid3 = '0;
    logic [2:0]  in_ready3;
    logic [1:0]  sel3 = '0;
    logic        mode3 = MODE_FIXED;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic        out_ready3 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_mux #(.W(8), .N(4)) dut4 (
        .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .sel(sel4), .mode(mode4), .out_data(out_data4),
        .out_valid(out_valid4), .out_ready(out_ready4)
    );

    stream_mux #(.W(8), .N(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .sel(sel3), .mode(mode3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3)
    );

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [7:0] exp_od;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic m, logic [1:0] s, logic [3:0] v, logic r,
                                logic [3:0] er, logic eov, logic [7:0] eod);
        vec_t t;
        t.mode = m; t.sel = s; t.vld = v; t.ordy = r;
        t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        // ch0=10 ch1=21 ch2=A5 ch3=43; reset leaves last=3 so ch0 leads round robin.
        vecs[0]  = mk(MODE_FIXED, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5);
        vecs[1]  = mk(MODE_FIXED, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5);
        vecs[2]  = mk(MODE_RR,    2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h43);
        vecs[3]  = mk(MODE_RR,    2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10);
        vecs[4]  = mk(MODE_RR,    2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h21);
        vecs[5]  = mk(MODE_RR,    2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5);
        vecs[6]  = mk(MODE_RR,    2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h43);
        vecs[7]  = mk(MODE_RR,    2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10);
        vecs[8]  = mk(MODE_RR,    2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h10);
        vecs[9]  = mk(MODE_FIXED, 2'd1, 4'b0001, 1'b1, 4'b0000, 1'b0, 8'h10);
        vecs[10] = mk(MODE_RR,    2'd0, 4'b1010, 1'b0, 4'b0010, 1'b1, 8'h21);
        vecs[11] = mk(MODE_RR,    2'd0, 4'b1010, 1'b0, 4'b0000, 1'b1, 8'h21);
        vecs[12] = mk(MODE_RR,    2'd0, 4'b1010, 1'b0, 4'b0000, 1'b1, 8'h21);
        vecs[13] = mk(MODE_RR,    2'd0, 4'b1010, 1'b0, 4'b0000, 1'b1, 8'h21);
        vecs[14] = mk(MODE_RR,    2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h43);
        vecs[15] = mk(MODE_FIXED, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h43);
        vecs[16] = mk(MODE_FIXED, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10);
        vecs[17] = mk(MODE_FIXED, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 8'h10);

        // Reset state, with valid traffic present that must not be granted.
        in_valid4 = 4'b1111;
        out_ready4 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid4), 32'd0);
        chk("rst_out_data",  32'(out_data4),  32'h0);
        chk("rst_in_ready",  32'(in_ready4),  32'h0);
        chk("rst_in_ready3", 32'(in_ready3),  32'h0);
        in_valid4 = '0;
        rst = 1'b0;

        foreach (vecs[i]) begin
            mode4 = vecs[i].mode;
            sel4 = vecs[i].sel;
            in_valid4 = vecs[i].vld;
            out_ready4 = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready4), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid4), 32'(vecs[i].exp_ov));
            chk($sformatf("v%0d_out_data", i),  32'(out_data4),  32'(vecs[i].exp_od));
            @(negedge clk);
        end

        // Load ch1 (last=0) and hold it, then pulse reset between edges.
        mode4 = MODE_RR; in_valid4 = 4'b1111; out_ready4 = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_out_valid", 32'(out_valid4), 32'd1);
        chk("pre_rst_out_data",  32'(out_data4),  32'h21);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid4), 32'd0);
        chk("async_rst_out_data",  32'(out_data4),  32'h0);
        chk("async_rst_in_ready",  32'(in_ready4),  32'h0);
        #1 rst = 1'b0;
        out_ready4 = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready4), 32'b0001);
        @(posedge clk); #1;
        chk("post_rst_out_valid", 32'(out_valid4), 32'd1);
        chk("post_rst_out_data",  32'(out_data4),  32'h10);
        in_valid4 = '0;

        // Three-channel instance: out-of-range sel, then round robin wrap at 3.
        @(negedge clk);
        mode3 = MODE_FIXED; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
        repeat (2) begin
            #1;
            chk("n3_sel3_in_ready", 32'(in_ready3), 32'h0);
            @(posedge clk); #1;
            chk("n3_sel3_out_valid", 32'(out_valid3), 32'd0);
            @(negedge clk);
        end
        sel3 = 2'd2;
        #1;
        chk("n3_sel2_in_ready", 32'(in_ready3), 32'b100);
        @(posedge clk); #1;
        chk("n3_sel2_out_data", 32'(out_data3), 32'h03);
        @(negedge clk);
        mode3 = MODE_RR;
        for (int k = 0; k < 4; k++) begin
            logic [2:0] er;
            logic [7:0] ed;
            er = 3'b001 << (k % 3);
            ed = 8'(k % 3 + 1);
            #1;
            chk($sformatf("n3_rr%0d_in_ready", k), 32'(in_ready3), 32'(er));
            @(posedge clk); #1;
            chk($sformatf("n3_rr%0d_out_data", k), 32'(out_data3), 32'(ed));
            chk($sformatf("n3_rr%0d_out_valid", k), 32'(out_valid3), 32'd1);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
